// File: rtl/csr_trap_seq.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_seq
// Purpose  : Trap-entry / MRET sequencer and arbiter for the single access
//            port of the machine-mode CSR file. It shares the port between
//            core CSR instructions and its own multi-cycle sequences.
//            Trap entry writes mepc and mcause, updates mstatus, reads mtvec
//            and redirects fetch. MRET restores mstatus, reads mepc and
//            redirects fetch.
// Ports    : clk_i, rst_i (async, active-high)
//            core_*     core CSR request/grant/read-return channel
//            trap_*     trap request (cause, pc) and completion ack
//            mret_*     MRET request and completion ack
//            redirect_* fetch redirect pulse and target (target is held)
//            csr_*      CSR file port; read data returns one cycle after
//                       csr_re_o
// Options  : CSR_TRAP_VECTORED_EN - vectored interrupt targets when
//            mtvec[1:0]==2'b01
// Revision : 1.0 - initial release
// ============================================================================
module csr_trap_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  input  logic        trap_req_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  output logic        trap_ack_o,
  input  logic        mret_req_i,
  output logic        mret_ack_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] csr_addr_o,
  output logic        csr_we_o,
  output logic        csr_re_o,
  output logic [31:0] csr_wdata_o,
  input  logic [31:0] csr_rdata_i
);

  localparam logic [31:0] C_ADDR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] C_ADDR_MTVEC   = 32'h0000_0305;
  localparam logic [31:0] C_ADDR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] C_ADDR_MCAUSE  = 32'h0000_0342;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    TR_EPC   = 4'd1,
    TR_CAUSE = 4'd2,
    TR_STRD  = 4'd3,
    TR_STWR  = 4'd4,
    TR_VECRD = 4'd5,
    TR_REDIR = 4'd6,
    MR_STRD  = 4'd7,
    MR_STWR  = 4'd8,
    MR_EPCRD = 4'd9,
    MR_REDIR = 4'd10
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_cause;
  logic [31:0] r_pc;
  logic [31:0] r_redirect_pc;
  logic        r_rvalid;
  logic        w_core_gnt;
  logic        w_redir_valid;
  logic [31:0] w_redir_pc;
  logic [31:0] w_trap_target;
  logic [31:0] w_mstatus_trap;
  logic [31:0] w_mstatus_mret;

  // mstatus rewrites; csr_rdata_i carries the mstatus read issued the
  // previous cycle whenever these are consumed.
  always_comb begin
    w_mstatus_trap         = csr_rdata_i;
    w_mstatus_trap[7]      = csr_rdata_i[3];
    w_mstatus_trap[3]      = 1'b0;
    w_mstatus_trap[12:11]  = 2'b11;

    w_mstatus_mret         = csr_rdata_i;
    w_mstatus_mret[3]      = csr_rdata_i[7];
    w_mstatus_mret[7]      = 1'b1;
    w_mstatus_mret[12:11]  = 2'b11;
  end

`ifdef CSR_TRAP_VECTORED_EN
  // Vectored mode applies to interrupts only; exceptions use the base.
  always_comb begin
    if (csr_rdata_i[1:0] == 2'b01 && r_cause[31]) begin
      w_trap_target = {csr_rdata_i[31:2], 2'b00} + {25'd0, r_cause[4:0], 2'b00};
    end else begin
      w_trap_target = {csr_rdata_i[31:2], 2'b00};
    end
  end
`else
  assign w_trap_target = {csr_rdata_i[31:2], 2'b00};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_cause       <= '0;
      r_pc          <= '0;
      r_redirect_pc <= RESET_PC;
      r_rvalid      <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rvalid <= w_core_gnt && !core_we_i;
      // Trap operands are captured once so later input changes are ignored.
      if (r_state == IDLE && trap_req_i) begin
        r_cause <= trap_cause_i;
        r_pc    <= trap_pc_i;
      end
      if (w_redir_valid) begin
        r_redirect_pc <= w_redir_pc;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_core_gnt    = 1'b0;
    csr_addr_o    = '0;
    csr_we_o      = 1'b0;
    csr_re_o      = 1'b0;
    csr_wdata_o   = '0;
    trap_ack_o    = 1'b0;
    mret_ack_o    = 1'b0;
    w_redir_valid = 1'b0;
    w_redir_pc    = r_redirect_pc;

    case (r_state)
      IDLE: begin
        if (trap_req_i) begin
          w_next = TR_EPC;
        end else if (mret_req_i) begin
          w_next = MR_STRD;
        end else if (core_req_i) begin
          w_core_gnt  = 1'b1;
          csr_addr_o  = core_addr_i;
          csr_we_o    = core_we_i;
          csr_re_o    = !core_we_i;
          csr_wdata_o = core_wdata_i;
        end
      end
      TR_EPC: begin
        csr_addr_o  = C_ADDR_MEPC;
        csr_we_o    = 1'b1;
        csr_wdata_o = r_pc & ~32'h3;
        w_next      = TR_CAUSE;
      end
      TR_CAUSE: begin
        csr_addr_o  = C_ADDR_MCAUSE;
        csr_we_o    = 1'b1;
        csr_wdata_o = r_cause;
        w_next      = TR_STRD;
      end
      TR_STRD: begin
        csr_addr_o = C_ADDR_MSTATUS;
        csr_re_o   = 1'b1;
        w_next     = TR_STWR;
      end
      TR_STWR: begin
        csr_addr_o  = C_ADDR_MSTATUS;
        csr_we_o    = 1'b1;
        csr_wdata_o = w_mstatus_trap;
        w_next      = TR_VECRD;
      end
      TR_VECRD: begin
        csr_addr_o = C_ADDR_MTVEC;
        csr_re_o   = 1'b1;
        w_next     = TR_REDIR;
      end
      TR_REDIR: begin
        w_redir_valid = 1'b1;
        w_redir_pc    = w_trap_target;
        trap_ack_o    = 1'b1;
        w_next        = IDLE;
      end
      MR_STRD: begin
        csr_addr_o = C_ADDR_MSTATUS;
        csr_re_o   = 1'b1;
        w_next     = MR_STWR;
      end
      MR_STWR: begin
        csr_addr_o  = C_ADDR_MSTATUS;
        csr_we_o    = 1'b1;
        csr_wdata_o = w_mstatus_mret;
        w_next      = MR_EPCRD;
      end
      MR_EPCRD: begin
        csr_addr_o = C_ADDR_MEPC;
        csr_re_o   = 1'b1;
        w_next     = MR_REDIR;
      end
      MR_REDIR: begin
        w_redir_valid = 1'b1;
        w_redir_pc    = csr_rdata_i & ~32'h3;
        mret_ack_o    = 1'b1;
        w_next        = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign core_gnt_o       = w_core_gnt;
  assign core_rvalid_o    = r_rvalid;
  // Read data is only presented alongside its valid pulse.
  assign core_rdata_o     = r_rvalid ? csr_rdata_i : '0;
  assign redirect_valid_o = w_redir_valid;
  assign redirect_pc_o    = w_redir_pc;

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_csr_trap_seq
// Purpose  : Directed self-checking bench for csr_trap_seq with a small CSR
//            file model (mstatus, mtvec, mepc, mcause) on the CSR port.
//            Build with CSR_TRAP_VECTORED_EN to match the vectored build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_trap_seq;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        core_req_i, core_we_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic        core_gnt_o, core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        trap_req_i;
  logic [31:0] trap_cause_i, trap_pc_i;
  logic        trap_ack_o, mret_req_i, mret_ack_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] csr_addr_o, csr_wdata_o;
  logic        csr_we_o, csr_re_o;
  logic [31:0] csr_rdata_i;

  // CSR file model
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

  int n_total = 0;
  int n_pass  = 0;
  int both_err = 0;
  int gnt_leak = 0;
  int ack_seen = 0;
  logic [31:0] exp_vec;

  always #5 clk = ~clk;

  csr_trap_seq #(.RESET_PC(C_RESET_PC)) u_dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .core_req_i       (core_req_i),
    .core_we_i        (core_we_i),
    .core_addr_i      (core_addr_i),
    .core_wdata_i     (core_wdata_i),
    .core_gnt_o       (core_gnt_o),
    .core_rvalid_o    (core_rvalid_o),
    .core_rdata_o     (core_rdata_o),
    .trap_req_i       (trap_req_i),
    .trap_cause_i     (trap_cause_i),
    .trap_pc_i        (trap_pc_i),
    .trap_ack_o       (trap_ack_o),
    .mret_req_i       (mret_req_i),
    .mret_ack_o       (mret_ack_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .csr_addr_o       (csr_addr_o),
    .csr_we_o         (csr_we_o),
    .csr_re_o         (csr_re_o),
    .csr_wdata_o      (csr_wdata_o),
    .csr_rdata_i      (csr_rdata_i)
  );

  always @(posedge clk) begin
    if (csr_we_o && csr_re_o) both_err <= both_err + 1;
    if (csr_we_o) begin
      case (csr_addr_o)
        32'h300: m_mstatus <= csr_wdata_o;
        32'h305: m_mtvec   <= csr_wdata_o;
        32'h341: m_mepc    <= csr_wdata_o;
        32'h342: m_mcause  <= csr_wdata_o;
        default: ;
      endcase
    end
    if (csr_re_o) begin
      case (csr_addr_o)
        32'h300: csr_rdata_i <= m_mstatus;
        32'h305: csr_rdata_i <= m_mtvec;
        32'h341: csr_rdata_i <= m_mepc;
        32'h342: csr_rdata_i <= m_mcause;
        default: csr_rdata_i <= 32'h0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic core_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = a; core_wdata_i = d;
    #1 check("wr_gnt", {31'd0, core_gnt_o}, 32'd1);
    @(negedge clk);
    core_req_i = 1'b0; core_we_i = 1'b0;
  endtask

  task automatic core_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = a;
    #1 check({tag, "_gnt"}, {31'd0, core_gnt_o}, 32'd1);
    check({tag, "_re"}, {31'd0, csr_re_o}, 32'd1);
    @(negedge clk);
    core_req_i = 1'b0;
    #1 check({tag, "_rvalid"}, {31'd0, core_rvalid_o}, 32'd1);
    check({tag, "_rdata"}, core_rdata_o, exp);
  endtask

  // Called in the acceptance cycle, after inputs are applied. Returns in the
  // ack cycle; the caller drops the request on the following negedge.
  task automatic wait_ack(input bit is_trap, input int exp_lat,
                          input logic [31:0] exp_pc, input string tag);
    int   lat;
    logic ack;
    lat = 0;
    ack = is_trap ? trap_ack_o : mret_ack_o;
    while (!ack && lat < 20) begin
      @(negedge clk);
      if (lat == 0) begin
        trap_cause_i = 32'hFFFF_FFFF;
        trap_pc_i    = 32'hDEAD_BEEF;
      end
      #1;
      lat++;
      ack = is_trap ? trap_ack_o : mret_ack_o;
      if (core_req_i && core_gnt_o) gnt_leak++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rvalid"}, {31'd0, redirect_valid_o}, 32'd1);
    check({tag, "_rpc"}, redirect_pc_o, exp_pc);
    check({tag, "_otherack"}, {31'd0, is_trap ? mret_ack_o : trap_ack_o}, 32'd0);
  endtask

  initial begin
    m_mstatus = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; csr_rdata_i = 0;
    rst_i = 1'b1;
    core_req_i = 0; core_we_i = 0; core_addr_i = 0; core_wdata_i = 0;
    trap_req_i = 0; trap_cause_i = 0; trap_pc_i = 0; mret_req_i = 0;

    // Reset state
    #12;
    check("rst_trap_ack", {31'd0, trap_ack_o}, 32'd0);
    check("rst_mret_ack", {31'd0, mret_ack_o}, 32'd0);
    check("rst_rvalid",   {31'd0, redirect_valid_o}, 32'd0);
    check("rst_rpc",      redirect_pc_o, C_RESET_PC);
    check("rst_gnt",      {31'd0, core_gnt_o}, 32'd0);
    check("rst_crvalid",  {31'd0, core_rvalid_o}, 32'd0);
    check("rst_crdata",   core_rdata_o, 32'd0);
    check("rst_csr_we",   {31'd0, csr_we_o}, 32'd0);
    check("rst_csr_re",   {31'd0, csr_re_o}, 32'd0);
    check("rst_csr_addr", csr_addr_o, 32'd0);
    check("rst_csr_wd",   csr_wdata_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    // Core write/read
    core_write(32'h305, 32'h0000_1001);
    core_read(32'h305, 32'h0000_1001, "rd_mtvec");
    @(negedge clk);
    #1 check("rvalid_pulse", {31'd0, core_rvalid_o}, 32'd0);
    core_write(32'h305, 32'h0000_1000);
    core_write(32'h300, 32'h0000_0008);

    // Trap entry
    @(negedge clk);
    trap_req_i = 1; trap_cause_i = 32'h2; trap_pc_i = 32'h206;
    #1 wait_ack(1'b1, 6, 32'h0000_1000, "trap");
    @(negedge clk);
    trap_req_i = 0;
    #1 check("trap_rpc_hold", redirect_pc_o, 32'h0000_1000);
    check("trap_rv_pulse", {31'd0, redirect_valid_o}, 32'd0);
    check("trap_mepc", m_mepc, 32'h0000_0204);
    check("trap_mcause", m_mcause, 32'h2);
    check("trap_mstatus", m_mstatus, 32'h0000_1880);

    // MRET
    @(negedge clk);
    mret_req_i = 1;
    #1 wait_ack(1'b0, 4, 32'h0000_0204, "mret");
    @(negedge clk);
    mret_req_i = 0;
    #1 check("mret_mstatus", m_mstatus, 32'h0000_1888);

    // Vectored interrupt
    core_write(32'h305, 32'h0000_1001);
`ifdef CSR_TRAP_VECTORED_EN
    exp_vec = 32'h0000_101C;
`else
    exp_vec = 32'h0000_1000;
`endif
    @(negedge clk);
    trap_req_i = 1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h300;
    #1 wait_ack(1'b1, 6, exp_vec, "vec");
    @(negedge clk);
    trap_req_i = 0;
    #1 check("vec_mcause", m_mcause, 32'h8000_0007);
    check("vec_mstatus", m_mstatus, 32'h0000_1880);

    // Simultaneous requests
    @(negedge clk);
    trap_req_i = 1; trap_cause_i = 32'hB; trap_pc_i = 32'h40C;
    mret_req_i = 1;
    core_req_i = 1; core_we_i = 0; core_addr_i = 32'h305;
    #1 check("sim_gnt0", {31'd0, core_gnt_o}, 32'd0);
    wait_ack(1'b1, 6, 32'h0000_1000, "sim_trap");
    @(negedge clk);
    trap_req_i = 0;
    #1 check("sim_gnt1", {31'd0, core_gnt_o}, 32'd0);
    check("sim_mret_noack", {31'd0, mret_ack_o}, 32'd0);
    wait_ack(1'b0, 4, 32'h0000_040C, "sim_mret");
    @(negedge clk);
    mret_req_i = 0;
    #1 check("sim_core_gnt", {31'd0, core_gnt_o}, 32'd1);
    @(negedge clk);
    core_req_i = 0;
    #1 check("sim_core_rdata", core_rdata_o, 32'h0000_1001);
    check("sim_mstatus", m_mstatus, 32'h0000_1880);
    check("sim_mepc", m_mepc, 32'h0000_040C);
    check("sim_gnt_leak", gnt_leak, 32'd0);

    // Reset during TR_STRD
    core_write(32'h300, 32'h0000_0008);
    @(negedge clk);
    trap_req_i = 1; trap_cause_i = 32'h5; trap_pc_i = 32'h111;
    repeat (3) @(negedge clk);
    #1 check("rs_strd_re", {31'd0, csr_re_o}, 32'd1);
    check("rs_strd_addr", csr_addr_o, 32'h300);
    rst_i = 1; trap_req_i = 0;
    #1 check("rs_csr_re", {31'd0, csr_re_o}, 32'd0);
    check("rs_csr_addr", csr_addr_o, 32'd0);
    check("rs_rpc", redirect_pc_o, C_RESET_PC);
    check("rs_ack", {31'd0, trap_ack_o}, 32'd0);
    @(negedge clk);
    rst_i = 0;
    repeat (8) begin
      @(negedge clk);
      #1 if (trap_ack_o || redirect_valid_o) ack_seen++;
    end
    check("rs_no_ack", ack_seen, 32'd0);
    check("rs_mepc", m_mepc, 32'h0000_0110);
    check("rs_mcause", m_mcause, 32'h5);
    check("rs_mstatus", m_mstatus, 32'h0000_0008);
    core_read(32'h342, 32'h5, "rs_rd");

    check("we_re_both", both_err, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csr_trap_seq.md
# csr_trap_seq

Trap/return sequencer and port arbiter for the machine-mode CSR register file. It owns the single CSR file access port and shares it between the core's CSR-instruction requests and its own multi-cycle trap-entry and MRET sequences. During trap entry it writes mepc and mcause, updates mstatus, reads mtvec and issues a PC redirect to fetch. During MRET it restores mstatus, reads mepc and issues the redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value on redirect_pc_o after reset.

Ports (reset rst_i, asynchronous, active-high; clock clk_i):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- core_req_i  in  1  core CSR access request, held until granted
- core_we_i  in  1  1 = write, 0 = read
- core_addr_i  in  32  CSR address (0x300, 0x305, 0x341, 0x342, ...)
- core_wdata_i  in  32  write data
- core_gnt_o  out  1  request accepted this cycle
- core_rvalid_o  out  1  read data valid (one-cycle pulse)
- core_rdata_o  out  32  read data
- trap_req_i  in  1  exception/interrupt request, held until trap_ack_o
- trap_cause_i  in  32  mcause value; bit 31 = interrupt
- trap_pc_i  in  32  faulting PC
- trap_ack_o  out  1  trap sequence complete (pulse)
- mret_req_i  in  1  MRET request, held until mret_ack_o
- mret_ack_o  out  1  MRET sequence complete (pulse)
- redirect_valid_o  out  1  fetch redirect (pulse)
- redirect_pc_o  out  32  redirect target, holds its last value
- csr_addr_o  out  32  CSR file address
- csr_we_o  out  1  CSR file write enable
- csr_re_o  out  1  CSR file read enable
- csr_wdata_o  out  32  CSR file write data
- csr_rdata_i  in  32  CSR file read data, valid the cycle after csr_re_o

## Operation
- FSM states: IDLE, TR_EPC, TR_CAUSE, TR_STRD, TR_STWR, TR_VECRD, TR_REDIR, MR_STRD, MR_STWR, MR_EPCRD, MR_REDIR.
- IDLE priority: trap_req_i > mret_req_i > core_req_i. Only one request is serviced per cycle. A losing request is not acknowledged and must stay asserted.
- Core access, IDLE only:
  - core_gnt_o=1 combinationally.
  - The CSR port passes core_addr_i, core_we_i, core_wdata_i through, with csr_re_o=!core_we_i.
  - Reads pulse core_rvalid_o on the next cycle, with core_rdata_o=csr_rdata_i.
  - The FSM stays in IDLE, so back-to-back grants are allowed.
- Trap entry, IDLE->TR_EPC when trap_req_i:
  - TR_EPC: write 0x341 with trap_pc_i & ~3.
  - TR_CAUSE: write 0x342 with trap_cause_i.
  - TR_STRD: read 0x300.
  - TR_STWR: write 0x300 with rdata modified as follows: MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11; all other bits are unchanged.
  - TR_VECRD: read 0x305.
  - TR_REDIR: redirect_pc_o = target(csr_rdata_i); pulse redirect_valid_o and trap_ack_o; go to IDLE.
- MRET, IDLE->MR_STRD when mret_req_i:
  - MR_STRD: read 0x300.
  - MR_STWR: write 0x300 with MIE[3]=MPIE[7], MPIE[7]=1, MPP=2'b11.
  - MR_EPCRD: read 0x341.
  - MR_REDIR: redirect_pc_o = csr_rdata_i & ~3; pulse redirect_valid_o and mret_ack_o; go to IDLE.
- trap_cause_i and trap_pc_i are sampled into internal registers on acceptance. Later changes to them are ignored.
- Requests arriving mid-sequence are not acknowledged; they are evaluated on return to IDLE.
- Outside IDLE the CSR port is driven only by the FSM. csr_we_o and csr_re_o are never both 1.

## Timing
- Reset values:
  - All outputs are 0, except redirect_pc_o=RESET_PC.
  - The FSM is in IDLE and the internal registers are 0.
- Reset asserted mid-sequence: FSM returns to IDLE immediately with no ack and no redirect. CSR writes already issued remain in the CSR file.
- Trap latency: trap_req_i sampled in IDLE at cycle N; trap_ack_o and redirect_valid_o at cycle N+6.
- MRET latency: acknowledged at cycle N+4.
- Core read: gnt at cycle N, rvalid at N+1. Core write completes at cycle N.
- A trap_req_i that is still asserted in the cycle after its ack starts a new sequence. Requesters deassert on ack.

## Configuration
- CSR_TRAP_VECTORED_EN defined:
  - If mtvec[1:0]==2'b01 and trap_cause_i[31]=1, target = {mtvec[31:2],2'b00} + 4*trap_cause_i[4:0].
  - Otherwise target = {mtvec[31:2],2'b00}.
- CSR_TRAP_VECTORED_EN undefined: mtvec[1:0] is ignored and target = {mtvec[31:2],2'b00} always.

## Test plan
- Core write then read: write 0x305 = 0x0000_1001 (gnt same cycle), then read 0x305 -> rvalid next cycle, rdata 0x0000_1001.
- Trap entry:
  - Setup: mstatus=0x0000_0008, mtvec=0x0000_1000.
  - Stimulus: trap_req_i with cause 0x0000_0002, pc 0x0000_0206.
  - Required: mepc=0x0000_0204, mcause=0x2, mstatus=0x0000_1880, redirect_pc_o=0x0000_1000, ack exactly 6 cycles after acceptance.
- Vectored interrupt:
  - Setup: mtvec=0x0000_1001, cause 0x8000_0007.
  - Required with CSR_TRAP_VECTORED_EN: redirect 0x0000_101C.
  - Required without it: redirect 0x0000_1000.
- MRET:
  - Setup: mstatus=0x0000_1880, mepc=0x0000_0204.
  - Required: mstatus=0x0000_1888, redirect 0x0000_0204, mret_ack_o 4 cycles after acceptance.
- Simultaneous requests:
  - Stimulus: trap_req_i, mret_req_i and core_req_i asserted in the same cycle.
  - Required: trap serviced first and core_gnt_o stays 0 throughout. MRET starts the cycle after trap_ack_o. The core is granted only after mret_ack_o.
- Reset during TR_STRD:
  - Required: all outputs return to 0 (redirect_pc_o=RESET_PC) with no ack. mepc and mcause keep their written values and mstatus is unchanged.
